// File: rtl/mult_pkg.sv
// Shared definitions for the multi-cycle multiply unit: default sizes, FSM encoding
// and the decoder out_select codes that identify MFHI/MFLO.
package mult_pkg;

    localparam int unsigned MULT_WIDTH = 32;
    localparam int unsigned MULT_CNT_W = 6;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_FIX  = 2'b10;

    localparam logic [1:0] OUT_HI = 2'b10;
    localparam logic [1:0] OUT_LO = 2'b11;

    typedef enum logic [1:0] {
        StIdle = S_IDLE,
        StRun  = S_RUN,
        StFix  = S_FIX
    } mult_state_e;

    // Decoder-side helper: out_select values that read HI or LO.
    function automatic logic is_mf_read(logic [1:0] out_select);
        return (out_select == OUT_HI) || (out_select == OUT_LO);
    endfunction

endpackage

// File: rtl/mult_shift_add.sv
// Radix-2 shift-add datapath: operand magnitudes, accumulator, W+1-bit adder and
// the HI/LO registers written with the sign-corrected product.
module mult_shift_add
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             finalize,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               neg_q;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] product;

    always_comb begin
        // The most negative value maps onto itself, which is its correct unsigned magnitude.
        abs_a   = (mult_sign && srca[WIDTH-1]) ? -srca : srca;
        abs_b   = (mult_sign && srcb[WIDTH-1]) ? -srcb : srcb;
        addend  = mplier_q[0] ? mcand_q : '0;
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_d   = {sum, acc_q[WIDTH-1:1]};
        product = neg_q ? -acc_q : acc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (load) begin
                mcand_q  <= abs_a;
                mplier_q <= abs_b;
                acc_q    <= '0;
                neg_q    <= mult_sign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            end else if (step) begin
                acc_q    <= acc_d;
                mplier_q <= mplier_q >> 1;
            end
            if (finalize) begin
                {hi_q, lo_q} <= product;
            end
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/mult_sequencer.sv
// Multiply sequencer for the pipelined core: IDLE/RUN/FIX control, iteration
// counter and the pipeline stall raised by MFHI/MFLO or MULT while busy.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned CNT_W = MULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mf_read,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall
);

    mult_state_e      state_q;
    mult_state_e      state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             load;
    logic             step;
    logic             finalize;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        load     = 1'b0;
        step     = 1'b0;
        finalize = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_mult) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                busy    = 1'b1;
                step    = 1'b1;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                busy     = 1'b1;
                finalize = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // A start in IDLE is accepted directly, so only a busy unit can stall.
        stall = busy & (mf_read | start_mult);
    end

    mult_shift_add #(
        .WIDTH (WIDTH)
    ) u_shift_add (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .finalize  (finalize),
        .mult_sign (mult_sign),
        .srca      (srca),
        .srcb      (srcb),
        .hi        (hi),
        .lo        (lo)
    );

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed corner products, stall behaviour,
// back-to-back starts, asynchronous reset and randomized operands against a product model.
module tb_mult_sequencer;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start_mult = 1'b0;
    logic         mult_sign = 1'b0;
    logic [W-1:0] srca = '0;
    logic [W-1:0] srcb = '0;
    logic         mf_read = 1'b0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         stall;

    int n_checks = 0;
    int n_pass   = 0;

    logic [2*W-1:0] model_hilo = '0;

    mult_sequencer #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .mult_sign  (mult_sign),
        .srca       (srca),
        .srcb       (srcb),
        .mf_read    (mf_read),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h required %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: random mf_read and operand noise while busy
    // mode 1: mf_read held from cycle 2 onward
    // mode 2: start_mult held with the next operands (back-to-back)
    task automatic do_mult(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input int mode, input bit nsgn, input logic [31:0] na,
                           input logic [31:0] nb);
        logic [63:0] exp;
        exp        = ref_mul(sgn, a, b);
        start_mult = 1'b1;
        mult_sign  = sgn;
        srca       = a;
        srcb       = b;
        mf_read    = 1'b0;
        #1;
        check("idle_start", {busy, stall, hi, lo}, {1'b0, 1'b0, model_hilo});
        for (int cyc = 1; cyc <= W + 1; cyc++) begin
            tick();
            if (mode == 2) begin
                start_mult = 1'b1;
                mult_sign  = nsgn;
                srca       = na;
                srcb       = nb;
                mf_read    = 1'b0;
            end else begin
                start_mult = 1'b0;
                mult_sign  = 1'($urandom);
                srca       = $urandom;
                srcb       = $urandom;
                mf_read    = (mode == 1) ? (cyc >= 2) : 1'($urandom);
            end
            #1;
            check("busy_hold", {busy, stall, hi, lo},
                  {1'b1, (mode == 2) | mf_read, model_hilo});
        end
        tick();
        model_hilo = exp;
        if (mode != 2) begin
            start_mult = 1'b0;
            mf_read    = (mode == 1) ? 1'b1 : 1'($urandom);
        end
        #1;
        check("result", {busy, stall, hi, lo}, {1'b0, 1'b0, model_hilo});
        if (mode != 2) begin
            mf_read = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] ra2;
        logic [31:0] rb2;
        bit          rs;
        bit          rs2;

        reset = 1'b1;
        tick();
        tick();
        #1;
        reset = 1'b0;
        #1;
        check("reset_state", {busy, stall, hi, lo}, 66'd0);

        do_mult(1'b0, 32'd7, 32'd6, 0, 1'b0, 0, 0);
        check("multu_7x6_lo", {34'd0, lo}, {34'd0, 32'h0000002A});
        do_mult(1'b1, 32'hFFFFFFFD, 32'd5, 0, 1'b0, 0, 0);
        check("mult_m3x5", {2'b0, hi, lo}, {2'b0, 32'hFFFFFFFF, 32'hFFFFFFF1});
        do_mult(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 0, 0);
        check("multu_max", {2'b0, hi, lo}, {2'b0, 32'hFFFFFFFE, 32'h00000001});
        do_mult(1'b1, 32'h80000000, 32'h80000000, 0, 1'b0, 0, 0);
        check("mult_min", {2'b0, hi, lo}, {2'b0, 32'h40000000, 32'h00000000});

        // MFHI held from cycle 2: stall until the result lands.
        do_mult(1'b1, 32'h12345678, 32'hFEDCBA98, 1, 1'b0, 0, 0);

        // Back-to-back: second multiply accepted on the cycle-34 edge, result in cycle 68.
        do_mult(1'b0, 32'hDEADBEEF, 32'h00010001, 2, 1'b1, 32'hFFFF0000, 32'h7FFFFFFF);
        do_mult(1'b1, 32'hFFFF0000, 32'h7FFFFFFF, 0, 1'b0, 0, 0);

        // Asynchronous reset during RUN cycle 10.
        start_mult = 1'b1;
        mult_sign  = 1'b0;
        srca       = 32'h0000FFFF;
        srcb       = 32'h0000FFFF;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            start_mult = 1'b0;
        end
        #2;
        check("pre_reset_busy", {65'd0, busy}, {65'd0, 1'b1});
        mf_read    = 1'b1;
        start_mult = 1'b1;
        reset      = 1'b1;
        model_hilo = '0;
        #1;
        check("async_reset", {busy, stall, hi, lo}, 66'd0);
        tick();
        #1;
        check("reset_held", {busy, stall, hi, lo}, 66'd0);
        reset      = 1'b0;
        start_mult = 1'b0;
        mf_read    = 1'b0;
        tick();
        do_mult(1'b0, 32'd2, 32'd3, 0, 1'b0, 0, 0);
        check("post_reset_2x3", {2'b0, hi, lo}, {2'b0, 32'd0, 32'd6});

        for (int i = 0; i < 16; i++) begin
            rs  = 1'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            rs2 = 1'($urandom);
            ra2 = $urandom;
            rb2 = $urandom;
            if (i % 4 == 3) begin
                do_mult(rs, ra, rb, 2, rs2, ra2, rb2);
                do_mult(rs2, ra2, rb2, 0, 1'b0, 0, 0);
            end else begin
                do_mult(rs, ra, rb, i % 2, 1'b0, 0, 0);
            end
            if (($urandom % 3) == 0) begin
                tick();
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Multi-cycle multiply unit and its sequencer for the pipelined MIPS core.
- Consumes the decoder's start_mult and mult_sign strobes together with the ID/EX operands.
- Runs a radix-2 shift-add multiply over WIDTH cycles and holds the HI/LO registers.
- Raises a pipeline stall when MFHI, MFLO or a new MULT/MULTU arrives while a multiply is in flight.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- CNT_W, 6: iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start_mult  input  1  MULT/MULTU is in EX this cycle.
- mult_sign  input  1  1 = MULT (signed), 0 = MULTU; sampled with start_mult.
- srca  input  WIDTH  rs operand.
- srcb  input  WIDTH  rt operand.
- mf_read  input  1  MFHI or MFLO is in EX this cycle (decoder out_select 10 or 11).
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  multiply in progress (states RUN and FIX).
- stall  output  1  freeze PC, IF/ID and ID/EX; insert a bubble into EX/MEM.

Behaviour:
- Reset (asynchronous) forces: state = IDLE, hi = 0, lo = 0, busy = 0, stall = 0, count = 0, accumulator = 0. A reset mid-operation discards the product; HI/LO read 0.
- States:
  - IDLE:
    - If start_mult = 1, latch |srca| and |srcb| into the multiplicand and multiplier registers.
    - |x| applies only when mult_sign = 1; otherwise the raw value is used.
    - Latch neg = mult_sign & (srca[W-1] ^ srcb[W-1]), clear the 2W-bit accumulator, set count = 0, go to RUN.
  - RUN (one multiplier bit per cycle):
    - If the multiplier LSB = 1, the accumulator's upper half += multiplicand (carry kept, W+1 bits).
    - Shift the accumulator and multiplier right by 1; count += 1.
    - When count == WIDTH-1 on this edge, go to FIX.
  - FIX (one cycle):
    - Write {hi,lo} = neg ? -(accumulator) (2W-bit two's complement) : accumulator. Go to IDLE.
- Signed magnitude: |0x80000000| = 0x80000000, taken as an unsigned W-bit value. No overflow special case is needed.
- Latency:
  - The start edge is cycle 0. RUN occupies cycles 1..WIDTH; FIX is cycle WIDTH+1.
  - The new HI/LO is visible after the edge that ends FIX, i.e. valid in cycle WIDTH+2 (34 for W=32).
- busy = 1 exactly in RUN and FIX (combinational from state).
- stall = busy & (mf_read | start_mult) (combinational):
  - MFHI/MFLO cannot read stale HI/LO.
  - A second MULT is held in EX until IDLE, then accepted.
- start_mult in IDLE never stalls.
- Simultaneous start_mult and mf_read in IDLE is impossible (one EX instruction); if both occur, start wins and no stall is raised.
- Operand changes after the start edge are ignored; operands are latched.
- HI/LO keep their previous value throughout RUN/FIX and change only at the FIX edge.
- Non-multiply instructions pass freely while busy; there is no stall without mf_read or start_mult.

Decomposition:
- Shared package mult_pkg:
  - State encoding localparams S_IDLE = 2'b00, S_RUN = 2'b01, S_FIX = 2'b10.
  - Default WIDTH/CNT_W.
  - Decoder out_select codes OUT_HI = 2'b10, OUT_LO = 2'b11, used to derive mf_read.
- One natural sub-module, mult_shift_add:
  - Holds the accumulator, multiplicand and multiplier registers and the W+1-bit adder.
  - Controls: load, step, finalize/negate.
  - The FSM, counter and stall logic stay in mult_sequencer.

Test Plan:
- MULTU 7 × 6:
  - Pulse start_mult with mult_sign = 0, srca = 7, srcb = 6.
  - Required: busy is 1 for cycles 1..33; in cycle 34, hi = 0x00000000 and lo = 0x0000002A.
- MULT −3 × 5:
  - srca = 0xFFFFFFFD, srcb = 5, mult_sign = 1.
  - Required: hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- MULTU and MULT corner values:
  - MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
  - MULT 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0x00000000.
- MFHI while busy:
  - Hold mf_read = 1 starting at cycle 2 after the start edge.
  - Required: stall = 1 through cycle 33, stall = 0 in cycle 34 with the new hi visible.
  - Required: the previous hi is unchanged until the FIX edge.
- Back-to-back MULT:
  - Hold start_mult = 1 continuously from cycle 0 with different operands.
  - Required: stall = 1 during cycles 1..33; the second multiply starts on the cycle-34 edge, and its result appears in cycle 68.
- Reset mid-operation:
  - Assert reset asynchronously in cycle 10 of RUN.
  - Required: hi = lo = 0, busy = 0 and stall = 0 immediately without a clock; after release, a new MULTU 2 × 3 yields lo = 6.
